// File: rtl/yd_dbus_resp_pkg.sv
// Shared definitions for the YD data-bus responder: MMIO page layout, control/status bit
// positions and the read-data source select.
package yd_dbus_resp_pkg;

  localparam logic [11:0] MmioPage = 12'hFFF;

  localparam logic [3:0] RegGpioOut = 4'h0;
  localparam logic [3:0] RegGpioIn  = 4'h1;
  localparam logic [3:0] RegTmrCnt  = 4'h2;
  localparam logic [3:0] RegTmrCmp  = 4'h3;
  localparam logic [3:0] RegTmrCtl  = 4'h4;
  localparam logic [3:0] RegTxq     = 4'h5;
  localparam logic [3:0] RegTxStat  = 4'h6;

  localparam int unsigned CtlEnBit   = 0;
  localparam int unsigned CtlIenBit  = 1;
  localparam int unsigned CtlFlagBit = 2;

  localparam int unsigned StatEmptyBit = 0;
  localparam int unsigned StatFullBit  = 2;
  localparam int unsigned StatOvfBit   = 3;

  // Which registered source drives d_dout this cycle.
  typedef enum logic [1:0] {
    SelZero,
    SelRam,
    SelMmio
  } rd_sel_e;

  function automatic logic is_mmio(input logic [15:0] addr);
    return addr[15:4] == MmioPage;
  endfunction

endpackage

// File: rtl/yd_dbus_resp_fifo.sv
// Small synchronous FIFO with registered storage and head; a push while full is accepted only
// when a pop happens in the same cycle.
module yd_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] DepthC = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [PtrW:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop  = pop_i & (cnt_q != '0);
    do_push = push_i & ((cnt_q != DepthC) | do_pop);
    rd_d    = rd_q + PtrW'(do_pop);
    wr_d    = wr_q + PtrW'(do_push);
    cnt_d   = cnt_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (do_push) begin
        mem_q[wr_q] <= data_i;
      end
    end
  end

  assign head_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == DepthC);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/yd_dbus_resp.sv
// YD core data-bus responder: word RAM plus an MMIO page (GPIO, compare timer, byte TX queue),
// returning registered read data one clock after the address is presented.
module yd_dbus_resp
  import yd_dbus_resp_pkg::*;
#(
  parameter int unsigned AW  = 10,
  parameter int unsigned GW  = 8,
  parameter int unsigned PSC = 16,
  parameter int unsigned FD  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   d_addr,
  input  logic [15:0]   d_din,
  input  logic          d_we,
  output logic [15:0]   d_dout,
  output logic [GW-1:0] gpio_o,
  input  logic [GW-1:0] gpio_i,
  output logic          irq,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready
);

  localparam int unsigned RamDepth = 2 ** AW;
  localparam int unsigned PscW     = (PSC > 1) ? $clog2(PSC) : 1;
  localparam logic [PscW-1:0] PscLast = PscW'(PSC - 1);

  logic          sel_mmio, wr_mmio, ram_we;
  logic [3:0]    off;
  logic [AW-1:0] ram_idx;

  assign sel_mmio = is_mmio(d_addr);
  assign off      = d_addr[3:0];
  assign ram_idx  = d_addr[AW-1:0];
  assign wr_mmio  = d_we & sel_mmio & ~rst;
  assign ram_we   = d_we & ~sel_mmio & ~rst;

  // RAM: sync-read array, read-first on a same-address write.
  logic [15:0] mem_q [RamDepth];
  logic [15:0] ram_rd_q;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_q[ram_idx] <= d_din;
    end
    ram_rd_q <= mem_q[ram_idx];
  end

  logic [GW-1:0]   gpio_out_q, gpio_out_d, gpio_s1_q, gpio_s2_q;
  logic [15:0]     cnt_q, cnt_d, cmp_q, cmp_d, mmio_rd_q, mmio_rd_d;
  logic [PscW-1:0] psc_q, psc_d;
  logic            en_q, en_d, ien_q, ien_d, flag_q, flag_d, ovf_q, ovf_d;
  rd_sel_e         rd_sel_q, rd_sel_d;
  logic            tick, flag_set, push, pop;
  logic            fifo_full, fifo_empty;
  logic [$clog2(FD):0] fifo_count;
  logic [7:0]      fifo_head;

  assign pop  = tx_valid & tx_ready;
  assign push = wr_mmio & (off == RegTxq);

  always_comb begin
    gpio_out_d = gpio_out_q;
    cnt_d      = cnt_q;
    cmp_d      = cmp_q;
    psc_d      = psc_q;
    en_d       = en_q;
    ien_d      = ien_q;
    flag_d     = flag_q;
    ovf_d      = ovf_q;
    tick       = en_q & (psc_q == PscLast);
    flag_set   = tick & (cnt_q == cmp_q);

    if (en_q) begin
      psc_d = tick ? '0 : psc_q + 1'b1;
    end
    if (tick) begin
      cnt_d = flag_set ? '0 : cnt_q + 16'd1;
    end

    if (wr_mmio) begin
      case (off)
        RegGpioOut: gpio_out_d = d_din[GW-1:0];
        RegTmrCnt: begin
          cnt_d = d_din;
          psc_d = '0;
        end
        RegTmrCmp: cmp_d = d_din;
        RegTmrCtl: begin
          en_d  = d_din[CtlEnBit];
          ien_d = d_din[CtlIenBit];
          if (d_din[CtlFlagBit]) begin
            flag_d = 1'b0;
          end
        end
        RegTxStat: ovf_d = 1'b0;
        default: ;
      endcase
    end

    // A match in the same cycle as a W1C leaves the flag set.
    if (flag_set) begin
      flag_d = 1'b1;
    end
    if (push & fifo_full & ~pop) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    mmio_rd_d = '0;
    case (off)
      RegGpioOut: mmio_rd_d = 16'(gpio_out_q);
      RegGpioIn:  mmio_rd_d = 16'(gpio_s2_q);
      RegTmrCnt:  mmio_rd_d = cnt_q;
      RegTmrCmp:  mmio_rd_d = cmp_q;
      RegTmrCtl:  mmio_rd_d = {13'b0, flag_q, ien_q, en_q};
      RegTxStat:  mmio_rd_d = {12'b0, ovf_q, fifo_full, 1'b0, fifo_empty};
      default:    mmio_rd_d = '0;
    endcase
    rd_sel_d = sel_mmio ? SelMmio : SelRam;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out_q <= '0;
      gpio_s1_q  <= '0;
      gpio_s2_q  <= '0;
      cnt_q      <= '0;
      cmp_q      <= '0;
      psc_q      <= '0;
      en_q       <= 1'b0;
      ien_q      <= 1'b0;
      flag_q     <= 1'b0;
      ovf_q      <= 1'b0;
      mmio_rd_q  <= '0;
      rd_sel_q   <= SelZero;
    end else begin
      gpio_out_q <= gpio_out_d;
      gpio_s1_q  <= gpio_i;
      gpio_s2_q  <= gpio_s1_q;
      cnt_q      <= cnt_d;
      cmp_q      <= cmp_d;
      psc_q      <= psc_d;
      en_q       <= en_d;
      ien_q      <= ien_d;
      flag_q     <= flag_d;
      ovf_q      <= ovf_d;
      mmio_rd_q  <= mmio_rd_d;
      rd_sel_q   <= rd_sel_d;
    end
  end

  always_comb begin
    d_dout = '0;
    unique case (rd_sel_q)
      SelRam:  d_dout = ram_rd_q;
      SelMmio: d_dout = mmio_rd_q;
      default: d_dout = '0;
    endcase
  end

  yd_sync_fifo #(
    .Width(8),
    .Depth(FD)
  ) u_txq (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (d_din[7:0]),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign gpio_o   = gpio_out_q;
  assign irq      = flag_q & ien_q;
  assign tx_data  = fifo_head;
  assign tx_valid = (fifo_count != '0);

endmodule
